fwd_scoreboard: RTL and testbench
=================================

// Module: fwd_scoreboard
// PURPOSE
//  Parametrised forwarding and load-use hazard unit for the pipelined core.
//  Tracks destination registers of in-flight instructions across DEPTH post-decode stages.
//  Selects the youngest valid producer for each source operand and raises a stall on load-use hazards.
//  Keeps saturating stall and forward event counters; sits between decode (Reg_File read) and execute.
// PARAMETERS
//  DSIZE        16  data width
//  RSIZE        4   register address width
//  DEPTH        3   tracked stages after decode (0=EX, 1=MEM, ..., DEPTH-1=WB); range 2..8
//  LOAD_STAGE   1   first stage index at which load data is valid in res_data; range 1..DEPTH-1
//  R0_HARDWIRED 0   1: rd==0 never forwarded, never stalls
//  CNT_W        16  width of event counters
// PORTS
//  clk        in   1            clock, rising edge
//  rst        in   1            asynchronous reset, active-low
//  issue_vld  in   1            decode stage holds a valid instruction
//  issue_wen  in   1            instruction writes the register file
//  issue_load in   1            instruction is a load
//  issue_rd   in   RSIZE        destination register
//  rs1, rs2   in   RSIZE        source registers of the decoding instruction
//  rf_rdata1  in   DSIZE        Reg_File read data for rs1
//  rf_rdata2  in   DSIZE        Reg_File read data for rs2
//  res_data   in   DEPTH*DSIZE  result of stage k on bits [k*DSIZE +: DSIZE]
//  flush      in   1            kill decode instruction and stage-0 entry
//  opnd1      out  DSIZE        forwarded operand 1
//  opnd2      out  DSIZE        forwarded operand 2
//  fwd_hit1   out  1            opnd1 taken from res_data
//  fwd_hit2   out  1            opnd2 taken from res_data
//  stall      out  1            hold PC and decode this cycle
//  stall_cnt  out  CNT_W        cycles with stall=1, saturating
//  fwd_cnt    out  CNT_W        accepted issues with fwd_hit1|fwd_hit2, saturating
// BEHAVIOUR
//  - State: DEPTH entries {vld, wen, load, rd}; entry k is the instruction in stage k.
//  - Reset (rst=0, async): all entries vld=0; stall_cnt=fwd_cnt=0.
//    With entries empty: stall=0, fwd_hit*=0, opnd*=rf_rdata*.
//  - Match(k, rs) = vld[k] & wen[k] & rd[k]==rs & !(R0_HARDWIRED & rs==0).
//  - Operand select is combinational; the lowest matching k (youngest) wins.
//    Then opnd = res_data slice k and fwd_hit=1; no match: opnd = rf_rdata, fwd_hit=0.
//  - Stall:
//    - Raised when the winning match for rs1 or rs2 is a load with k < LOAD_STAGE.
//    - Masked to 0 when flush=1 or issue_vld=0.
//    - When stall=1, the stalled operand's opnd/fwd_hit are don't-care.
//  - Accepted issue = issue_vld & !stall & !flush.
//  - Each posedge:
//    - Entry k+1 <= entry k; entry DEPTH-1 retires (Reg_File write same edge).
//    - Entry 0 <= {1, issue_wen, issue_load, issue_rd} if accepted, else bubble (vld=0).
//    - When flush=1, the value shifted out of entry 0 into entry 1 is also cleared to a bubble.
//  - Counters:
//    - stall_cnt +1 on cycles with stall=1.
//    - fwd_cnt +1 on accepted issues with fwd_hit1|fwd_hit2.
//    - Both hold at 2^CNT_W-1.
//  - Timing: a stall lasts LOAD_STAGE-k cycles, then the load is forwarded from stage LOAD_STAGE.
//    A producer in stage DEPTH-1 is forwarded in its retire cycle (Reg_File read not yet updated).
//  - Reset mid-operation clears all entries; in-flight hazards are forgotten.
//    rst is deasserted synchronously to clk at system level.
// TESTING
//  1. ALU dependency: issue ADD rd=3, then rs1=3 next cycle, res_data[0]=0x1234
//     -> opnd1=0x1234, fwd_hit1=1, stall=0, fwd_cnt=1.
//  2. Load-use (LOAD_STAGE=1): LW rd=5, then rs2=5
//     -> stall=1 one cycle, stall_cnt=1; next cycle res_data[1]=0xBEEF -> opnd2=0xBEEF.
//  3. Same rd=7 in stage 0 (0x0001) and stage 2 (0x0002), rs1=rs2=7
//     -> opnd1=opnd2=0x0001 (youngest wins).
//  4. R0_HARDWIRED=1: stage 0 writes rd=0, rs1=0, rf_rdata1=0x0000
//     -> fwd_hit1=0, opnd1=0x0000, no stall even when the producer is a load.
//  5. Load-use with flush=1 in the same cycle
//     -> stall=0, entry 0 and entry 1 become bubbles, stall_cnt unchanged.
//  6. rst pulled low mid-stream with 3 valid entries and counters nonzero
//     -> immediately stall=0, fwd_hit*=0, counters=0; rerun cases 1-2 with DEPTH=4, LOAD_STAGE=2 -> 2-cycle stall.

Source files
------------

// File: rtl/fwd_scoreboard_if.sv
// rtl/fwd_scoreboard_if.sv - decode/execute side signals of the forwarding scoreboard
interface fwd_scoreboard_if #(
  parameter int DSIZE = 16,
  parameter int RSIZE = 4,
  parameter int DEPTH = 3,
  parameter int CNT_W = 16
);
  logic                   issue_vld;
  logic                   issue_wen;
  logic                   issue_load;
  logic [RSIZE-1:0]       issue_rd;
  logic [RSIZE-1:0]       rs1;
  logic [RSIZE-1:0]       rs2;
  logic [DSIZE-1:0]       rf_rdata1;
  logic [DSIZE-1:0]       rf_rdata2;
  logic [DEPTH*DSIZE-1:0] res_data;
  logic                   flush;
  logic [DSIZE-1:0]       opnd1;
  logic [DSIZE-1:0]       opnd2;
  logic                   fwd_hit1;
  logic                   fwd_hit2;
  logic                   stall;
  logic [CNT_W-1:0]       stall_cnt;
  logic [CNT_W-1:0]       fwd_cnt;

  modport master (
    output issue_vld, issue_wen, issue_load, issue_rd, rs1, rs2,
    output rf_rdata1, rf_rdata2, res_data, flush,
    input  opnd1, opnd2, fwd_hit1, fwd_hit2, stall, stall_cnt, fwd_cnt
  );

  modport slave (
    input  issue_vld, issue_wen, issue_load, issue_rd, rs1, rs2,
    input  rf_rdata1, rf_rdata2, res_data, flush,
    output opnd1, opnd2, fwd_hit1, fwd_hit2, stall, stall_cnt, fwd_cnt
  );
endinterface

// File: rtl/fwd_scoreboard.sv
// rtl/fwd_scoreboard.sv - forwarding and load-use hazard unit with event counters
module fwd_scoreboard #(
  parameter int DSIZE        = 16,
  parameter int RSIZE        = 4,
  parameter int DEPTH        = 3,
  parameter int LOAD_STAGE   = 1,
  parameter int R0_HARDWIRED = 0,
  parameter int CNT_W        = 16
) (
  input logic           clk,
  input logic           rst,
  fwd_scoreboard_if.slave sb
);

  // Per-stage record of the in-flight instruction; index 0 is EX.
  logic [DEPTH-1:0] e_vld;
  logic [DEPTH-1:0] e_wen;
  logic [DEPTH-1:0] e_load;
  logic [RSIZE-1:0] e_rd [DEPTH];

  logic [DSIZE-1:0] res_slice [DEPTH];

  logic             hit1, hit2;
  logic             early1, early2;
  logic [DSIZE-1:0] fwd1, fwd2;
  logic             r0_blk1, r0_blk2;
  logic             stall;
  logic             accepted;

  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] fwd_cnt_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_slice
    assign res_slice[g] = sb.res_data[g*DSIZE +: DSIZE];
  end

  // Pick the youngest matching producer per operand; scanning oldest to youngest
  // lets the lowest stage index overwrite any older match.
  always_comb begin
    hit1    = 1'b0;
    hit2    = 1'b0;
    early1  = 1'b0;
    early2  = 1'b0;
    fwd1    = '0;
    fwd2    = '0;
    r0_blk1 = (R0_HARDWIRED != 0) && (sb.rs1 == '0);
    r0_blk2 = (R0_HARDWIRED != 0) && (sb.rs2 == '0);
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (e_vld[k] && e_wen[k] && (e_rd[k] == sb.rs1) && !r0_blk1) begin
        hit1   = 1'b1;
        early1 = e_load[k] && (k < LOAD_STAGE);
        fwd1   = res_slice[k];
      end
      if (e_vld[k] && e_wen[k] && (e_rd[k] == sb.rs2) && !r0_blk2) begin
        hit2   = 1'b1;
        early2 = e_load[k] && (k < LOAD_STAGE);
        fwd2   = res_slice[k];
      end
    end
  end

  // A load whose data is not yet on res_data holds decode; killed or empty
  // decode slots never stall.
  always_comb begin
    stall    = sb.issue_vld && !sb.flush && (early1 || early2);
    accepted = sb.issue_vld && !stall && !sb.flush;
  end

  assign sb.opnd1     = hit1 ? fwd1 : sb.rf_rdata1;
  assign sb.opnd2     = hit2 ? fwd2 : sb.rf_rdata2;
  assign sb.fwd_hit1  = hit1;
  assign sb.fwd_hit2  = hit2;
  assign sb.stall     = stall;
  assign sb.stall_cnt = stall_cnt_q;
  assign sb.fwd_cnt   = fwd_cnt_q;

  // Advance the pipeline record every cycle; flush kills both the decode slot
  // and the instruction leaving EX.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_vld  <= '0;
      e_wen  <= '0;
      e_load <= '0;
      for (int k = 0; k < DEPTH; k++) e_rd[k] <= '0;
    end else begin
      e_vld[0]  <= accepted;
      e_wen[0]  <= sb.issue_wen;
      e_load[0] <= sb.issue_load;
      e_rd[0]   <= sb.issue_rd;
      e_vld[1]  <= e_vld[0] && !sb.flush;
      for (int k = 2; k < DEPTH; k++) e_vld[k] <= e_vld[k-1];
      for (int k = 1; k < DEPTH; k++) begin
        e_wen[k]  <= e_wen[k-1];
        e_load[k] <= e_load[k-1];
        e_rd[k]   <= e_rd[k-1];
      end
    end
  end

  // Saturating event counters for stall cycles and forwarded issues.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      if (stall && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (accepted && (hit1 || hit2) && (fwd_cnt_q != {CNT_W{1'b1}}))
        fwd_cnt_q <= fwd_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb/tb_fwd_scoreboard.sv - directed self-checking bench for fwd_scoreboard
module tb_fwd_scoreboard;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  fwd_scoreboard_if #(.DSIZE(16), .RSIZE(4), .DEPTH(3), .CNT_W(16)) ia ();
  fwd_scoreboard_if #(.DSIZE(16), .RSIZE(4), .DEPTH(4), .CNT_W(2))  ib ();

  fwd_scoreboard #(.DSIZE(16), .RSIZE(4), .DEPTH(3), .LOAD_STAGE(1),
                   .R0_HARDWIRED(0), .CNT_W(16)) dut_a (
    .clk (clk),
    .rst (rst),
    .sb  (ia.slave)
  );

  fwd_scoreboard #(.DSIZE(16), .RSIZE(4), .DEPTH(4), .LOAD_STAGE(2),
                   .R0_HARDWIRED(1), .CNT_W(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .sb  (ib.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic w, input logic l,
                         input logic [3:0] rd, input logic [3:0] r1, input logic [3:0] r2);
    ia.issue_vld = v; ia.issue_wen = w; ia.issue_load = l;
    ia.issue_rd = rd; ia.rs1 = r1; ia.rs2 = r2;
  endtask

  task automatic drive_b(input logic v, input logic w, input logic l,
                         input logic [3:0] rd, input logic [3:0] r1, input logic [3:0] r2);
    ib.issue_vld = v; ib.issue_wen = w; ib.issue_load = l;
    ib.issue_rd = rd; ib.rs1 = r1; ib.rs2 = r2;
  endtask

  task automatic idle_a();
    drive_a(0, 0, 0, 4'd0, 4'd0, 4'd0);
    ia.flush = 0; ia.res_data = '0;
    ia.rf_rdata1 = 16'hA1A1; ia.rf_rdata2 = 16'hB2B2;
  endtask

  task automatic idle_b();
    drive_b(0, 0, 0, 4'd0, 4'd0, 4'd0);
    ib.flush = 0; ib.res_data = '0;
    ib.rf_rdata1 = 16'hA1A1; ib.rf_rdata2 = 16'hB2B2;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (ia.stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", ia.stall); end
    checks++; if (ia.fwd_hit1 !== 1'b0) begin failures++; $display("FAIL rst_hit1 got=%b exp=0", ia.fwd_hit1); end
    checks++; if (ia.fwd_hit2 !== 1'b0) begin failures++; $display("FAIL rst_hit2 got=%b exp=0", ia.fwd_hit2); end
    checks++; if (ia.opnd1 !== 16'hA1A1) begin failures++; $display("FAIL rst_opnd1 got=%h exp=a1a1", ia.opnd1); end
    checks++; if (ia.opnd2 !== 16'hB2B2) begin failures++; $display("FAIL rst_opnd2 got=%h exp=b2b2", ia.opnd2); end
    checks++; if (ia.stall_cnt !== 16'd0) begin failures++; $display("FAIL rst_stall_cnt got=%0d exp=0", ia.stall_cnt); end
    checks++; if (ia.fwd_cnt !== 16'd0) begin failures++; $display("FAIL rst_fwd_cnt got=%0d exp=0", ia.fwd_cnt); end
    checks++; if (ib.opnd1 !== 16'hA1A1) begin failures++; $display("FAIL rst_b_opnd1 got=%h exp=a1a1", ib.opnd1); end
    @(negedge clk);
    rst = 1;
    step();
  endtask

  task automatic test_alu_fwd();
    drive_a(1, 1, 0, 4'd3, 4'd0, 4'd0);
    step();
    drive_a(1, 0, 0, 4'd0, 4'd3, 4'd9);
    ia.res_data = {16'h0000, 16'h0000, 16'h1234};
    #1;
    checks++; if (ia.opnd1 !== 16'h1234) begin failures++; $display("FAIL alu_opnd1 got=%h exp=1234", ia.opnd1); end
    checks++; if (ia.fwd_hit1 !== 1'b1) begin failures++; $display("FAIL alu_hit1 got=%b exp=1", ia.fwd_hit1); end
    checks++; if (ia.fwd_hit2 !== 1'b0) begin failures++; $display("FAIL alu_hit2 got=%b exp=0", ia.fwd_hit2); end
    checks++; if (ia.opnd2 !== 16'hB2B2) begin failures++; $display("FAIL alu_opnd2 got=%h exp=b2b2", ia.opnd2); end
    checks++; if (ia.stall !== 1'b0) begin failures++; $display("FAIL alu_stall got=%b exp=0", ia.stall); end
    step();
    checks++; if (ia.fwd_cnt !== 16'd1) begin failures++; $display("FAIL alu_fwd_cnt got=%0d exp=1", ia.fwd_cnt); end
    checks++; if (ia.stall_cnt !== 16'd0) begin failures++; $display("FAIL alu_stall_cnt got=%0d exp=0", ia.stall_cnt); end
    idle_a();
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic test_load_use();
    drive_a(1, 1, 1, 4'd5, 4'd0, 4'd0);
    step();
    drive_a(1, 1, 0, 4'd6, 4'd1, 4'd5);
    ia.res_data = {16'h0000, 16'hBEEF, 16'h0000};
    #1;
    checks++; if (ia.stall !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b exp=1", ia.stall); end
    step();
    checks++; if (ia.stall_cnt !== 16'd1) begin failures++; $display("FAIL lu_stall_cnt got=%0d exp=1", ia.stall_cnt); end
    checks++; if (ia.stall !== 1'b0) begin failures++; $display("FAIL lu_stall_end got=%b exp=0", ia.stall); end
    checks++; if (ia.opnd2 !== 16'hBEEF) begin failures++; $display("FAIL lu_opnd2 got=%h exp=beef", ia.opnd2); end
    checks++; if (ia.fwd_hit2 !== 1'b1) begin failures++; $display("FAIL lu_hit2 got=%b exp=1", ia.fwd_hit2); end
    checks++; if (ia.fwd_hit1 !== 1'b0) begin failures++; $display("FAIL lu_hit1 got=%b exp=0", ia.fwd_hit1); end
    step();
    checks++; if (ia.fwd_cnt !== 16'd2) begin failures++; $display("FAIL lu_fwd_cnt got=%0d exp=2", ia.fwd_cnt); end
    checks++; if (ia.stall_cnt !== 16'd1) begin failures++; $display("FAIL lu_stall_hold got=%0d exp=1", ia.stall_cnt); end
    idle_a();
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic test_youngest();
    drive_a(1, 1, 0, 4'd7, 4'd0, 4'd0);
    step();
    drive_a(1, 1, 0, 4'd8, 4'd0, 4'd0);
    step();
    drive_a(1, 1, 0, 4'd7, 4'd0, 4'd0);
    step();
    drive_a(0, 0, 0, 4'd0, 4'd7, 4'd7);
    ia.res_data = {16'h0002, 16'h0003, 16'h0001};
    #1;
    checks++; if (ia.opnd1 !== 16'h0001) begin failures++; $display("FAIL young_opnd1 got=%h exp=0001", ia.opnd1); end
    checks++; if (ia.opnd2 !== 16'h0001) begin failures++; $display("FAIL young_opnd2 got=%h exp=0001", ia.opnd2); end
    checks++; if ((ia.fwd_hit1 & ia.fwd_hit2) !== 1'b1) begin failures++; $display("FAIL young_hits got=%b%b exp=11", ia.fwd_hit1, ia.fwd_hit2); end
    step();
    ia.rs1 = 4'd8;
    #1;
    checks++; if (ia.opnd1 !== 16'h0002) begin failures++; $display("FAIL retire_opnd1 got=%h exp=0002", ia.opnd1); end
    checks++; if (ia.opnd2 !== 16'h0003) begin failures++; $display("FAIL mem_opnd2 got=%h exp=0003", ia.opnd2); end
    checks++; if (ia.fwd_cnt !== 16'd2) begin failures++; $display("FAIL young_fwd_cnt got=%0d exp=2", ia.fwd_cnt); end
    idle_a();
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic test_r0();
    drive_a(1, 1, 0, 4'd0, 4'd0, 4'd0);
    drive_b(1, 1, 1, 4'd0, 4'd0, 4'd0);
    step();
    drive_a(1, 0, 0, 4'd0, 4'd0, 4'd9);
    drive_b(1, 0, 0, 4'd0, 4'd0, 4'd9);
    ia.rf_rdata1 = 16'h0000; ib.rf_rdata1 = 16'h0000;
    ia.res_data = {16'h0000, 16'h0000, 16'h5555};
    ib.res_data = {16'h0000, 16'h0000, 16'h0000, 16'h5555};
    #1;
    checks++; if (ia.fwd_hit1 !== 1'b1) begin failures++; $display("FAIL r0soft_hit1 got=%b exp=1", ia.fwd_hit1); end
    checks++; if (ia.opnd1 !== 16'h5555) begin failures++; $display("FAIL r0soft_opnd1 got=%h exp=5555", ia.opnd1); end
    checks++; if (ib.fwd_hit1 !== 1'b0) begin failures++; $display("FAIL r0hard_hit1 got=%b exp=0", ib.fwd_hit1); end
    checks++; if (ib.opnd1 !== 16'h0000) begin failures++; $display("FAIL r0hard_opnd1 got=%h exp=0000", ib.opnd1); end
    checks++; if (ib.stall !== 1'b0) begin failures++; $display("FAIL r0hard_stall got=%b exp=0", ib.stall); end
    step();
    checks++; if (ia.fwd_cnt !== 16'd3) begin failures++; $display("FAIL r0soft_fwd_cnt got=%0d exp=3", ia.fwd_cnt); end
    checks++; if (ib.fwd_cnt !== 2'd0) begin failures++; $display("FAIL r0hard_fwd_cnt got=%0d exp=0", ib.fwd_cnt); end
    idle_a();
    idle_b();
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic test_flush();
    drive_a(1, 1, 1, 4'd5, 4'd0, 4'd0);
    step();
    drive_a(1, 0, 0, 4'd0, 4'd1, 4'd5);
    ia.flush = 1;
    #1;
    checks++; if (ia.stall !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b exp=0", ia.stall); end
    step();
    idle_a();
    ia.rs2 = 4'd5;
    #1;
    checks++; if (ia.fwd_hit2 !== 1'b0) begin failures++; $display("FAIL flush_e1_hit2 got=%b exp=0", ia.fwd_hit2); end
    checks++; if (ia.opnd2 !== 16'hB2B2) begin failures++; $display("FAIL flush_opnd2 got=%h exp=b2b2", ia.opnd2); end
    checks++; if (ia.stall_cnt !== 16'd1) begin failures++; $display("FAIL flush_stall_cnt got=%0d exp=1", ia.stall_cnt); end
    checks++; if (ia.fwd_cnt !== 16'd3) begin failures++; $display("FAIL flush_fwd_cnt got=%0d exp=3", ia.fwd_cnt); end
    idle_a();
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic test_reset_mid();
    drive_a(1, 1, 0, 4'd1, 4'd0, 4'd0);
    step();
    drive_a(1, 1, 0, 4'd2, 4'd0, 4'd0);
    step();
    drive_a(1, 1, 1, 4'd4, 4'd0, 4'd0);
    step();
    drive_a(1, 0, 0, 4'd0, 4'd4, 4'd2);
    ia.res_data = {16'h0000, 16'h2222, 16'h0000};
    #1;
    checks++; if (ia.stall !== 1'b1) begin failures++; $display("FAIL mid_pre_stall got=%b exp=1", ia.stall); end
    #1;
    rst = 0;
    #1;
    checks++; if (ia.stall !== 1'b0) begin failures++; $display("FAIL mid_stall got=%b exp=0", ia.stall); end
    checks++; if ((ia.fwd_hit1 | ia.fwd_hit2) !== 1'b0) begin failures++; $display("FAIL mid_hits got=%b%b exp=00", ia.fwd_hit1, ia.fwd_hit2); end
    checks++; if (ia.opnd2 !== 16'hB2B2) begin failures++; $display("FAIL mid_opnd2 got=%h exp=b2b2", ia.opnd2); end
    checks++; if (ia.stall_cnt !== 16'd0) begin failures++; $display("FAIL mid_stall_cnt got=%0d exp=0", ia.stall_cnt); end
    checks++; if (ia.fwd_cnt !== 16'd0) begin failures++; $display("FAIL mid_fwd_cnt got=%0d exp=0", ia.fwd_cnt); end
    @(negedge clk);
    rst = 1;
    #1;
    checks++; if (ia.stall !== 1'b0) begin failures++; $display("FAIL mid_post_stall got=%b exp=0", ia.stall); end
    idle_a();
    step();
  endtask

  task automatic test_deep_rerun();
    drive_b(1, 1, 0, 4'd3, 4'd0, 4'd0);
    step();
    drive_b(1, 0, 0, 4'd0, 4'd3, 4'd9);
    ib.res_data = {16'h0000, 16'h0000, 16'h0000, 16'h1234};
    #1;
    checks++; if (ib.opnd1 !== 16'h1234) begin failures++; $display("FAIL deep_alu_opnd1 got=%h exp=1234", ib.opnd1); end
    checks++; if (ib.stall !== 1'b0) begin failures++; $display("FAIL deep_alu_stall got=%b exp=0", ib.stall); end
    step();
    checks++; if (ib.fwd_cnt !== 2'd1) begin failures++; $display("FAIL deep_alu_fwd_cnt got=%0d exp=1", ib.fwd_cnt); end
    idle_b();
    for (int i = 0; i < 4; i++) step();

    drive_b(1, 1, 1, 4'd5, 4'd0, 4'd0);
    step();
    drive_b(1, 1, 0, 4'd6, 4'd1, 4'd5);
    ib.res_data = {16'h0000, 16'hBEEF, 16'h0000, 16'h0000};
    #1;
    checks++; if (ib.stall !== 1'b1) begin failures++; $display("FAIL deep_lu_stall0 got=%b exp=1", ib.stall); end
    step();
    checks++; if (ib.stall !== 1'b1) begin failures++; $display("FAIL deep_lu_stall1 got=%b exp=1", ib.stall); end
    checks++; if (ib.stall_cnt !== 2'd1) begin failures++; $display("FAIL deep_lu_cnt1 got=%0d exp=1", ib.stall_cnt); end
    step();
    checks++; if (ib.stall !== 1'b0) begin failures++; $display("FAIL deep_lu_release got=%b exp=0", ib.stall); end
    checks++; if (ib.stall_cnt !== 2'd2) begin failures++; $display("FAIL deep_lu_cnt2 got=%0d exp=2", ib.stall_cnt); end
    checks++; if (ib.opnd2 !== 16'hBEEF) begin failures++; $display("FAIL deep_lu_opnd2 got=%h exp=beef", ib.opnd2); end
    checks++; if (ib.fwd_hit2 !== 1'b1) begin failures++; $display("FAIL deep_lu_hit2 got=%b exp=1", ib.fwd_hit2); end
    step();
    checks++; if (ib.fwd_cnt !== 2'd2) begin failures++; $display("FAIL deep_lu_fwd_cnt got=%0d exp=2", ib.fwd_cnt); end
    idle_b();
    for (int i = 0; i < 4; i++) step();

    drive_b(1, 1, 1, 4'd5, 4'd0, 4'd0);
    step();
    drive_b(1, 0, 0, 4'd0, 4'd0, 4'd5);
    ib.res_data = {16'h0000, 16'hBEEF, 16'h0000, 16'h0000};
    step();
    checks++; if (ib.stall_cnt !== 2'd3) begin failures++; $display("FAIL sat_stall_cnt3 got=%0d exp=3", ib.stall_cnt); end
    step();
    checks++; if (ib.stall_cnt !== 2'd3) begin failures++; $display("FAIL sat_stall_hold got=%0d exp=3", ib.stall_cnt); end
    checks++; if (ib.stall !== 1'b0) begin failures++; $display("FAIL sat_release got=%b exp=0", ib.stall); end
    step();
    checks++; if (ib.fwd_cnt !== 2'd3) begin failures++; $display("FAIL sat_fwd_cnt3 got=%0d exp=3", ib.fwd_cnt); end
    drive_b(1, 1, 0, 4'd3, 4'd0, 4'd0);
    step();
    drive_b(1, 0, 0, 4'd0, 4'd3, 4'd0);
    ib.res_data = {16'h0000, 16'h0000, 16'h0000, 16'h1234};
    #1;
    checks++; if (ib.fwd_hit1 !== 1'b1) begin failures++; $display("FAIL sat_pre_hit1 got=%b exp=1", ib.fwd_hit1); end
    step();
    checks++; if (ib.fwd_cnt !== 2'd3) begin failures++; $display("FAIL sat_fwd_hold got=%0d exp=3", ib.fwd_cnt); end
    idle_b();
    step();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    clk = 0;
    rst = 0;
    idle_a();
    idle_b();
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_youngest();
    test_r0();
    test_flush();
    test_reset_mid();
    test_deep_rerun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
